// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core front end.
//   - fetch_state_e : states of the instruction fetch FSM
//   - DEFAULT_RESET_PC : default reset program counter
//   - OPC_OP_IMM / OPC_OP : opcode[6:2] major-opcode values, also used by control
//   - INST_NOP : canonical NOP encoding (addi x0, x0, 0)
package core_pkg;

  typedef enum logic [1:0] {
    FETCH_ST = 2'd0,  // request outstanding at pc
    HOLD_ST  = 2'd1,  // fetched word presented to decode
    DROP_ST  = 2'd2   // waiting out the ack of a cancelled request
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit for the single-issue RV32I core.
// Holds the PC, issues one instruction-memory read at a time over req/ack,
// and presents each fetched word plus its PC to decode over valid/ready.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   imem_req/imem_addr        : read request and word-aligned byte address
//   imem_ack/imem_rdata       : read completion and returned word
//   redirect/redirect_pc      : one-cycle PC redirect from execute
//   inst_valid/inst_ready     : decode handshake
//   inst/inst_pc              : buffered instruction and its address
//   opcode/inst_legal         : inst[6:0] and inst[1:0]==2'b11, combinational
//
// Handshakes: imem_req/imem_addr are held constant from assertion until the
// cycle imem_ack is seen high (acks while imem_req is low are ignored).
// A word transfers to decode in every cycle where inst_valid & inst_ready.
module inst_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic        inst_legal
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic [31:0]  target;
  logic [1:0]   unused_redirect_lsbs;

  assign target               = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    case (state_q)
      FETCH_ST: begin
        if (redirect) begin
          pc_d = target;
          // Without an ack the request to the old pc is still live and must
          // be held until memory answers; with an ack it completes now and
          // its data is simply thrown away.
          if (!imem_ack) begin
            req_addr_d = pc_q;
            state_d    = DROP_ST;
          end
        end else if (imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          pc_d      = pc_q + 32'd4;  // wraps modulo 2^32
          state_d   = HOLD_ST;
        end
      end
      HOLD_ST: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH_ST;
        end else if (inst_ready) begin
          state_d = FETCH_ST;
        end
      end
      DROP_ST: begin
        // A redirect here only retargets pc; it wins even over a same-cycle
        // stale ack, so the old address is requested once more and dropped.
        if (redirect) begin
          pc_d = target;
        end else if (imem_ack) begin
          state_d = FETCH_ST;
        end
      end
      default: state_d = FETCH_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_ST;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      inst_q     <= 32'd0;
      inst_pc_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

  // Outputs are masked while rst is high so nothing is requested or offered
  // in the reset cycle, whatever state the flops held before it.
  assign imem_req   = !rst && (state_q == FETCH_ST || state_q == DROP_ST);
  assign imem_addr  = (state_q == DROP_ST) ? req_addr_q : pc_q;
  assign inst_valid = !rst && (state_q == HOLD_ST);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign opcode     = inst_q[6:0];
  assign inst_legal = (inst_q[1:0] == 2'b11);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req, imem_ack, redirect, inst_valid, inst_ready, inst_legal;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  logic [6:0]  opcode;

  // Memory model: zero-wait lookup table or manually driven ack/data.
  logic        zw_en, man_ack;
  logic [31:0] man_rdata, zw_word;

  // Second instance with a reset PC at the top of the address space.
  logic        w_req, w_valid, w_legal;
  logic [31:0] w_addr, w_inst, w_inst_pc;
  logic [6:0]  w_opcode;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (imem_addr)
      32'h0000_0000: zw_word = 32'h0000_0093;
      32'h0000_0004: zw_word = 32'h0010_8113;
      default:       zw_word = 32'h0000_0013;
    endcase
  end

  assign imem_ack   = zw_en ? imem_req : man_ack;
  assign imem_rdata = zw_en ? zw_word  : man_rdata;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .opcode(opcode), .inst_legal(inst_legal)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_req), .imem_rdata(32'h0000_0013),
    .redirect(1'b0), .redirect_pc(32'h0),
    .inst_valid(w_valid), .inst_ready(1'b1),
    .inst(w_inst), .inst_pc(w_inst_pc),
    .opcode(w_opcode), .inst_legal(w_legal)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0)   begin n_err++; $display("FAIL rst1_req got %b want 0", imem_req); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst1_valid got %b want 0", inst_valid); end
    n_cmp++; if (inst !== 32'd0)      begin n_err++; $display("FAIL rst1_inst got %h want 0", inst); end
    n_cmp++; if (inst_pc !== 32'd0)   begin n_err++; $display("FAIL rst1_inst_pc got %h want 0", inst_pc); end
    tick;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0)   begin n_err++; $display("FAIL rst2_req got %b want 0", imem_req); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst2_valid got %b want 0", inst_valid); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1)       begin n_err++; $display("FAIL post_rst_req got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0)     begin n_err++; $display("FAIL post_rst_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_seq_fetch;
    zw_en = 1'b1; inst_ready = 1'b1;
    tick;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1)        begin n_err++; $display("FAIL seq0_valid got %b want 1", inst_valid); end
    n_cmp++; if (inst !== 32'h0000_0093)     begin n_err++; $display("FAIL seq0_inst got %h want 00000093", inst); end
    n_cmp++; if (inst_pc !== 32'h0)          begin n_err++; $display("FAIL seq0_pc got %h want 0", inst_pc); end
    n_cmp++; if (opcode !== 7'b0010011)      begin n_err++; $display("FAIL seq0_opcode got %b want 0010011", opcode); end
    n_cmp++; if (inst_legal !== 1'b1)        begin n_err++; $display("FAIL seq0_legal got %b want 1", inst_legal); end
    n_cmp++; if (imem_req !== 1'b0)          begin n_err++; $display("FAIL seq0_req got %b want 0", imem_req); end
    tick;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1)          begin n_err++; $display("FAIL seq1_req got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h4)        begin n_err++; $display("FAIL seq1_addr got %h want 4", imem_addr); end
    tick;
    @(negedge clk);
    n_cmp++; if (inst !== 32'h0010_8113)     begin n_err++; $display("FAIL seq2_inst got %h want 00108113", inst); end
    n_cmp++; if (inst_pc !== 32'h4)          begin n_err++; $display("FAIL seq2_pc got %h want 4", inst_pc); end
    n_cmp++; if (opcode !== 7'b0010011)      begin n_err++; $display("FAIL seq2_opcode got %b want 0010011", opcode); end
    inst_ready = 1'b0; zw_en = 1'b0;
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 5; i++) begin
      tick;
      @(negedge clk);
      n_cmp++; if (inst_valid !== 1'b1)    begin n_err++; $display("FAIL bp_valid[%0d] got %b want 1", i, inst_valid); end
      n_cmp++; if (imem_req !== 1'b0)      begin n_err++; $display("FAIL bp_req[%0d] got %b want 0", i, imem_req); end
      n_cmp++; if (inst !== 32'h0010_8113) begin n_err++; $display("FAIL bp_inst[%0d] got %h want 00108113", i, inst); end
    end
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1)   begin n_err++; $display("FAIL bp_rel_req got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL bp_rel_addr got %h want 8", imem_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL bp_rel_valid got %b want 0", inst_valid); end
  endtask

  task automatic test_redirect_outstanding;
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick;
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1)   begin n_err++; $display("FAIL rdo_req[%0d] got %b want 1", i, imem_req); end
      n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL rdo_addr[%0d] got %h want 8", i, imem_addr); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rdo_valid[%0d] got %b want 0", i, inst_valid); end
      if (i == 0) tick;
    end
    man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    tick;
    man_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0)   begin n_err++; $display("FAIL rdo_stale_valid got %b want 0", inst_valid); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL rdo_new_addr got %h want 100", imem_addr); end
    man_ack = 1'b1; man_rdata = 32'h0000_0013;
    tick;
    man_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (inst !== 32'h0000_0013) begin n_err++; $display("FAIL rdo_inst got %h want 00000013", inst); end
    n_cmp++; if (inst_pc !== 32'h100)    begin n_err++; $display("FAIL rdo_inst_pc got %h want 100", inst_pc); end
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_addr !== 32'h104) begin n_err++; $display("FAIL rdo_next_addr got %h want 104", imem_addr); end
  endtask

  task automatic test_simultaneous;
    man_ack = 1'b1; man_rdata = 32'h1111_1111; redirect = 1'b1; redirect_pc = 32'h0000_0203;
    tick;
    man_ack = 1'b0; redirect = 1'b0;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0)   begin n_err++; $display("FAIL sim_ack_valid got %b want 0", inst_valid); end
    n_cmp++; if (imem_addr !== 32'h200) begin n_err++; $display("FAIL sim_ack_addr got %h want 200", imem_addr); end
    n_cmp++; if (inst_pc !== 32'h100)   begin n_err++; $display("FAIL sim_ack_inst_pc got %h want 100", inst_pc); end
    man_ack = 1'b1; man_rdata = 32'h00A0_0093;
    tick;
    man_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (inst_pc !== 32'h200) begin n_err++; $display("FAIL sim_hold_pc got %h want 200", inst_pc); end
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick;
    inst_ready = 1'b0; redirect = 1'b0;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0)      begin n_err++; $display("FAIL sim_hs_valid got %b want 0", inst_valid); end
    n_cmp++; if (imem_addr !== 32'h200)    begin n_err++; $display("FAIL sim_hs_addr got %h want 200", imem_addr); end
    n_cmp++; if (inst !== 32'h00A0_0093)   begin n_err++; $display("FAIL sim_hs_inst got %h want 00a00093", inst); end
  endtask

  task automatic test_wrap;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (w_req !== 1'b1)           begin n_err++; $display("FAIL wrap_req0 got %b want 1", w_req); end
    n_cmp++; if (w_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr0 got %h want fffffffc", w_addr); end
    tick;
    @(negedge clk);
    n_cmp++; if (w_inst_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_inst_pc got %h want fffffffc", w_inst_pc); end
    n_cmp++; if (w_req !== 1'b0)              begin n_err++; $display("FAIL wrap_hold_req got %b want 0", w_req); end
    tick;
    @(negedge clk);
    n_cmp++; if (w_req !== 1'b1)    begin n_err++; $display("FAIL wrap_req1 got %b want 1", w_req); end
    n_cmp++; if (w_addr !== 32'h0)  begin n_err++; $display("FAIL wrap_addr1 got %h want 0", w_addr); end
  endtask

  task automatic test_reset_in_drop;
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick;
    redirect = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rdrop_held_addr got %h want 0", imem_addr); end
    rst = 1'b1; man_ack = 1'b1; man_rdata = 32'hBAD0_0BAD;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rdrop_rst_req got %b want 0", imem_req); end
    tick;
    rst = 1'b0; man_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1)   begin n_err++; $display("FAIL rdrop_req got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rdrop_addr got %h want 0", imem_addr); end
    man_ack = 1'b1; man_rdata = 32'h0000_0013;
    tick;
    man_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL rdrop_fresh_valid got %b want 1", inst_valid); end
    n_cmp++; if (inst_pc !== 32'h0)   begin n_err++; $display("FAIL rdrop_fresh_pc got %h want 0", inst_pc); end
  endtask

  initial begin
    rst = 1'b1; zw_en = 1'b0; man_ack = 1'b0; man_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    test_reset;
    test_seq_fetch;
    test_backpressure;
    test_redirect_outstanding;
    test_simultaneous;
    test_wrap;
    test_reset_in_drop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the single-issue RV32I core. Holds the program counter, issues one read at a time to instruction memory over a req/ack handshake, and presents each fetched word with its PC to decode over a valid/ready handshake. Decode passes `opcode` straight to the `control` decoder. Branch/jump redirects from execute cancel any in-flight or buffered fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: read request to instruction memory.
- `imem_addr`  out  32: byte address of the request, word aligned.
- `imem_ack`  in  1: read done; `imem_rdata` is valid this cycle.
- `imem_rdata`  in  32: instruction word.
- `redirect`  in  1: one-cycle pulse from execute that loads a new PC.
- `redirect_pc`  in  32: redirect target; bits [1:0] are ignored and treated as 0.
- `inst_valid`  out  1: `inst` and `inst_pc` are valid for decode.
- `inst_ready`  in  1: decode accepts the word this cycle.
- `inst`  out  32: buffered instruction word.
- `inst_pc`  out  32: address of `inst`.
- `opcode`  out  7: `inst[6:0]`, combinational; drives `control`.
- `inst_legal`  out  1: `inst[1:0] == 2'b11`, combinational.

## Operation
- **State machine:** FETCH, HOLD, DROP. Registers: `pc`, `req_addr`, `inst`, `inst_pc`.
- **Reset:** state = FETCH, `pc` = RESET_PC, `inst_valid` = 0, `inst` = 0, `inst_pc` = 0. `imem_req` is 0 during the reset cycle.
- **FETCH:**
  - `imem_req` = 1 and `imem_addr` = `pc`.
  - On `imem_ack`: `inst` ← `imem_rdata`, `inst_pc` ← `pc`, `pc` ← `pc` + 4, go to HOLD.
- **HOLD:**
  - `inst_valid` = 1 and `imem_req` = 0.
  - On `inst_valid & inst_ready`: go to FETCH.
- **DROP:**
  - `imem_req` = 1 and `imem_addr` = `req_addr`, the address of the cancelled request.
  - On `imem_ack`: discard `imem_rdata`, go to FETCH.
- **Request rule:** once asserted, `imem_req` and `imem_addr` stay constant until `imem_ack`. Only one request is ever outstanding.
- **Redirect** has priority over every other transition and always sets `pc` ← `{redirect_pc[31:2], 2'b00}`. Per state:
  - FETCH without ack: `req_addr` ← current `pc`, go to DROP.
  - FETCH with ack in the same cycle: discard the data, stay in FETCH. The new address appears next cycle.
  - HOLD: go to FETCH with `inst_valid` = 0 next cycle. A handshake in the same cycle still counts as consumed by decode.
  - DROP: update `pc` only, stay in DROP.
- **Arithmetic:** `pc` + 4 wraps modulo 2^32. 32'hFFFF_FFFC is followed by 32'h0000_0000.
- **Output stability:** `inst` and `inst_pc` change only on FETCH→HOLD.

## Timing
- `imem_ack` sampled in cycle N → `inst_valid` = 1 in cycle N+1.
- Handshake in cycle M → `imem_req` = 1 in cycle M+1 at the next PC.
- Zero-wait memory (ack in the same cycle as req) gives a peak rate of 1 instruction per 2 cycles.
- `redirect` in cycle R → `imem_addr` = target no earlier than R+1. In DROP it is delayed until the cycle after the stale ack.
- `imem_ack` while `imem_req` = 0 is ignored.
- `rst` takes effect in the cycle it is sampled, overriding everything, including an outstanding request.
- The memory must tolerate an abandoned request after reset.

## Structure
- **Shared package `core_pkg`:**
  - fetch state enum.
  - default RESET_PC.
  - RV32I opcode constants: `OPC_OP_IMM` = 5'b00100 and `OPC_OP` = 5'b01100 (opcode[6:2]), also used by `control`.
  - `INST_NOP` = 32'h0000_0013.
- No sub-module. The single-entry instruction register is inlined; the block is one FSM plus a datapath.

## Test plan
- **Reset:** hold `rst` 2 cycles → `inst_valid` = 0, `imem_req` = 0; first cycle after reset `imem_req` = 1, `imem_addr` = RESET_PC.
- **Sequential fetch:** zero-wait memory returning 32'h0000_0093, 32'h0010_8113; `inst_ready` = 1 → `inst_pc` = 0 then 4, `opcode` = 7'b0010011, `inst_legal` = 1.
- **Backpressure:** `inst_ready` low for 5 cycles in HOLD → `inst` stable and `imem_req` = 0 throughout; next address issued the cycle after `inst_ready` rises.
- **Redirect during an outstanding request:** memory delays ack 3 cycles, `redirect` to 32'h0000_0100 in the first wait cycle → `imem_addr` held at the old PC until ack, stale data never presented, then `imem_addr` = 32'h100.
- **Simultaneous events:**
  - `redirect` (target 32'h203, expect 32'h200) in the same cycle as `imem_ack` → no `inst_valid`; next `imem_addr` = 32'h200.
  - `redirect` during a HOLD handshake → next `imem_addr` = 32'h200.
- **Wrap and reset:**
  - RESET_PC = 32'hFFFF_FFFC → second fetch address is 32'h0.
  - `rst` asserted mid-DROP → the following cycle starts a fresh fetch at RESET_PC.
